circle_ctrl: RTL
================

# circle_ctrl

Control FSM that sequences the circle datapath: optional screen clear through the embedded fillscreen, offset/criterion initialisation, eight octant plot cycles per Bresenham step, and the two-cycle offset/criterion update. It sits between the top-level start/done handshake and the datapath's control strobes, and reads back `offset_x`, `offset_y` and `crit` to make its decisions. It owns no arithmetic: all pixel math stays in the datapath.

## Interface
Parameters:
- `OFFSET_X_DW`, default 9: width of the signed `offset_x` feedback.
- `OFFSET_Y_DW`, default 8: width of the signed `offset_y` feedback.
- `CRIT_DW`, default 9: width of the signed `crit` feedback.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  draw request from top; level, held until `done`.
- `done`  out  1  circle complete; held until `start` falls.
- `busy`  out  1  high in every state except IDLE and DONE.
- `fill_start`  out  1  to the fillscreen start input.
- `fill_done`  in  1  from the fillscreen done output.
- `draw_circle`  out  1  selects circle plot path over fill path.
- `octant_sel`  out  3  octant index 0–7.
- `load_x_init`, `load_y_init`, `load_crit`  out  1 each  initialisation strobes.
- `inc_y`, `dec_x`  out  1 each  step strobes into the datapath `calc_offset` registers.
- `calc_crit`, `load_x_next`, `load_y_next`  out  1 each  commit strobes.
- `offset_x`  in  OFFSET_X_DW signed  current x offset.
- `offset_y`  in  OFFSET_Y_DW signed  current y offset.
- `crit`  in  CRIT_DW signed  current criterion.

## Operation
- **States:** IDLE, FILL, INIT, CHECK, OCT, UPD1, UPD2, DONE. A 3-bit octant counter runs inside OCT.
- **IDLE:** all strobes are 0. `start`=1 moves to FILL, or to INIT if the clear feature is compiled out.
- **FILL:**
  - `fill_start`=1 and `draw_circle`=0.
  - `fill_done`=1 moves to INIT. `fill_start` deasserts at that edge.
- **INIT:** one cycle with `load_x_init`, `load_y_init` and `load_crit` all 1. Moves to CHECK.
- **CHECK:**
  - Compares `offset_y`, sign-extended to OFFSET_X_DW, against `offset_x`, signed.
  - `offset_y` ≤ `offset_x` moves to OCT with the counter at 0. Otherwise moves to DONE.
- **OCT:**
  - `draw_circle`=1 and `octant_sel`=counter, for 8 cycles (0..7).
  - After counter 7, moves to UPD1.
  - The plot qualification (on/off screen) is the datapath's job, not the controller's.
- **UPD1:**
  - `inc_y`=1.
  - `dec_x` = (`crit` > 0), combinational from `crit` in this state only.
  - Moves to UPD2.
- **UPD2:**
  - `calc_crit`, `load_x_next` and `load_y_next` = 1. `inc_y` and `dec_x` = 0.
  - Moves to CHECK.
- **DONE:** `done`=1, other strobes 0. `start`=0 moves to IDLE.
- **Outputs:** all are Moore decodes of the state, except `dec_x`.
- **`draw_circle`:** 1 in INIT through UPD2, 0 in IDLE, FILL and DONE.
- **`start` handling:** `start` is ignored outside IDLE and DONE. Dropping it mid-draw does not abort.
- **Negative radius:** CHECK fails immediately, giving no plots and DONE.

## Timing
- **Reset:** `resetn`=0 forces IDLE immediately (asynchronous). All outputs go to 0 and the octant counter clears, including mid-fill or mid-octant.
- **Per Bresenham step:** 11 cycles (8 OCT + UPD1 + UPD2 + CHECK).
- **Latency, clear compiled out:** with `start` sampled at edge 0, INIT is cycle 1, CHECK cycle 2, and OCT cycles 3+.
- **Latency, clear compiled in:** the FILL duration is inserted before INIT.
- **`done`:** asserted the cycle after the failing CHECK.
- **Return to IDLE:** DONE→IDLE takes one cycle after `start` falls. A new `start` is accepted on the following edge.
- **Simultaneous events:** `fill_done` and `start` changes in the same cycle are decided by the current state only.

## Configuration
- **Macro:** `CIRCLE_CTRL_CLEAR_EN`.
- **Defined:** the FILL state exists and each draw first clears the screen.
- **Undefined:**
  - FILL is removed and IDLE goes directly to INIT.
  - `fill_start` is tied to 0 and `fill_done` is ignored.
  - The existing screen content is preserved.

## Structure
- **Shared package:** `circle_pkg` holds:
  - the state enum `circle_state_t`;
  - the octant constants `OCT_FIRST`=0 and `OCT_LAST`=7;
  - default widths for OFFSET_X_DW, OFFSET_Y_DW and CRIT_DW.
- **Sub-modules:** none. The octant counter is a few lines inside the FSM.

## Test plan
All scenarios use a behavioural datapath model.
- **Radius 0, centre (80,60), clear compiled out:** `start` → 8 OCT cycles, each plotting (80,60), `octant_sel` stepping 0..7. `done` rises 14 cycles after `start` is sampled.
- **Radius 1:** 16 OCT cycles (2 steps). `dec_x` is 0 in the first UPD1 (`crit`=0) and 1 in the second (`crit`=3). Final offsets are x=0, y=2.
- **Radius -1:** INIT, CHECK, then DONE with no `draw_circle`-qualified OCT cycle. `done` rises at cycle 3.
- **Clear compiled in, `fill_done` returned after 19200 cycles:**
  - `fill_start` is high throughout FILL and `draw_circle` stays 0.
  - INIT occurs on the cycle after `fill_done`.
- **`resetn` pulsed low during OCT counter 4:** all outputs go to 0 immediately. After release, IDLE waits for `start`, then a full redraw starts from octant 0.
- **`start` held high after DONE:** `done` stays 1 and there is no restart. `start` low then high starts exactly one new draw.

Source files
------------

// File: rtl/circle_pkg.sv
// Shared types and constants for the circle controller: state encoding,
// octant bounds and default feedback widths.
package circle_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        INIT  = 3'd2,
        CHECK = 3'd3,
        OCT   = 3'd4,
        UPD1  = 3'd5,
        UPD2  = 3'd6,
        DONE  = 3'd7
    } circle_state_t;

    localparam logic [2:0] OCT_FIRST = 3'd0;
    localparam logic [2:0] OCT_LAST  = 3'd7;

    localparam int OFFSET_X_DW_DEF = 9;
    localparam int OFFSET_Y_DW_DEF = 8;
    localparam int CRIT_DW_DEF     = 9;

endpackage

// File: rtl/circle_ctrl.sv
// Control FSM sequencing the Bresenham circle datapath (clear, init, 8 octant
// plots per step, two-cycle update). Screen clear is built with CIRCLE_CTRL_CLEAR_EN.
//
// Handshake: start is a level request sampled only in IDLE (and DONE, to leave
// it); done stays high in DONE until start is observed low, then IDLE follows.
module circle_ctrl
    import circle_pkg::*;
#(
    parameter int OFFSET_X_DW = OFFSET_X_DW_DEF,
    parameter int OFFSET_Y_DW = OFFSET_Y_DW_DEF,
    parameter int CRIT_DW     = CRIT_DW_DEF
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    output logic                          done,
    output logic                          busy,
    output logic                          fill_start,
    input  logic                          fill_done,
    output logic                          draw_circle,
    output logic [2:0]                    octant_sel,
    output logic                          load_x_init,
    output logic                          load_y_init,
    output logic                          load_crit,
    output logic                          inc_y,
    output logic                          dec_x,
    output logic                          calc_crit,
    output logic                          load_x_next,
    output logic                          load_y_next,
    input  logic signed [OFFSET_X_DW-1:0] offset_x,
    input  logic signed [OFFSET_Y_DW-1:0] offset_y,
    input  logic signed [CRIT_DW-1:0]     crit,
    output circle_state_t                 dbg_state
);

    localparam int CMP_DW = (OFFSET_X_DW > OFFSET_Y_DW) ? OFFSET_X_DW : OFFSET_Y_DW;

    circle_state_t            r_state;
    circle_state_t            w_next_state;
    logic [2:0]               r_oct;
    logic signed [CMP_DW-1:0] w_x_ext;
    logic signed [CMP_DW-1:0] w_y_ext;
    logic                     w_step_ok;
    logic                     w_crit_pos;

    assign w_x_ext    = CMP_DW'(offset_x);
    assign w_y_ext    = CMP_DW'(offset_y);
    assign w_step_ok  = (w_y_ext <= w_x_ext);
    assign w_crit_pos = !crit[CRIT_DW-1] && (crit != '0);
    assign dbg_state  = r_state;

`ifndef CIRCLE_CTRL_CLEAR_EN
    logic w_unused_fill_done;
    assign w_unused_fill_done = fill_done;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Counter free-runs only in OCT and is held at zero elsewhere, so every
    // entry into OCT starts at the first octant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_oct <= OCT_FIRST;
        end else if (r_state == OCT) begin
            r_oct <= r_oct + 3'd1;
        end else begin
            r_oct <= OCT_FIRST;
        end
    end

    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        busy         = 1'b0;
        fill_start   = 1'b0;
        draw_circle  = 1'b0;
        octant_sel   = 3'd0;
        load_x_init  = 1'b0;
        load_y_init  = 1'b0;
        load_crit    = 1'b0;
        inc_y        = 1'b0;
        dec_x        = 1'b0;
        calc_crit    = 1'b0;
        load_x_next  = 1'b0;
        load_y_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef CIRCLE_CTRL_CLEAR_EN
                    w_next_state = FILL;
`else
                    w_next_state = INIT;
`endif
                end
            end
`ifdef CIRCLE_CTRL_CLEAR_EN
            FILL: begin
                busy       = 1'b1;
                fill_start = 1'b1;
                if (fill_done) w_next_state = INIT;
            end
`endif
            INIT: begin
                busy         = 1'b1;
                draw_circle  = 1'b1;
                load_x_init  = 1'b1;
                load_y_init  = 1'b1;
                load_crit    = 1'b1;
                w_next_state = CHECK;
            end
            CHECK: begin
                busy         = 1'b1;
                draw_circle  = 1'b1;
                w_next_state = w_step_ok ? OCT : DONE;
            end
            OCT: begin
                busy        = 1'b1;
                draw_circle = 1'b1;
                octant_sel  = r_oct;
                if (r_oct == OCT_LAST) w_next_state = UPD1;
            end
            UPD1: begin
                busy         = 1'b1;
                draw_circle  = 1'b1;
                inc_y        = 1'b1;
                dec_x        = w_crit_pos;
                w_next_state = UPD2;
            end
            UPD2: begin
                busy         = 1'b1;
                draw_circle  = 1'b1;
                calc_crit    = 1'b1;
                load_x_next  = 1'b1;
                load_y_next  = 1'b1;
                w_next_state = CHECK;
            end
            DONE: begin
                done = 1'b1;
                if (!start) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule
